// File: rtl/brightness_timeout.sv
// Display-on window timer for one BCM brightness bit-plane of the LED matrix driver.
// Optional macro BRIGHTNESS_TIMEOUT_BLANK_GUARD_EN adds a one-cycle blanking guard after each load.

package types;
    typedef logic [7:0] brightness_level_t;
endpackage

module brightness_timeout #(
    parameter int _UNUSED    = 0,
    parameter int BASE_TICKS = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    row_latch,
    input  types::brightness_level_t brightness_mask_active,
    output logic                    output_enable,
    output logic                    exceeded_overlap_time
);

    localparam int W = $bits(types::brightness_level_t);
    // _UNUSED only keeps old instantiations legal; folding it in with *0 leaves the width unchanged.
    localparam int CNT_W = W + $clog2(BASE_TICKS) + 1 + (_UNUSED * 0);

    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_nxt;
    logic [CNT_W-1:0] load_val;
    logic             row_latch_q;
    logic             exceeded;
    logic             exceeded_nxt;
    logic             latch_pulse;
    logic             mask_nz;
    logic             guard_q;

    assign latch_pulse = row_latch & ~row_latch_q;
    assign mask_nz     = |brightness_mask_active;

    // Later iterations overwrite earlier ones, so the highest set bit selects the weight.
    always_comb begin
        load_val = '0;
        for (int i = 0; i < W; i++) begin
            if (brightness_mask_active[i]) begin
                load_val = CNT_W'(BASE_TICKS) << i;
            end
        end
    end

    always_comb begin
        counter_nxt  = counter;
        exceeded_nxt = exceeded;
        if (latch_pulse) begin
            counter_nxt  = mask_nz ? load_val : '0;
            exceeded_nxt = ~mask_nz;
        end else if ((counter != '0) && !guard_q) begin
            counter_nxt = counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
                exceeded_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            row_latch_q <= 1'b0;
            exceeded    <= 1'b0;
        end else begin
            counter     <= counter_nxt;
            row_latch_q <= row_latch;
            exceeded    <= exceeded_nxt;
        end
    end

`ifdef BRIGHTNESS_TIMEOUT_BLANK_GUARD_EN
    // Guard holds the freshly loaded count for one clock while the panel stays dark.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            guard_q <= 1'b0;
        end else begin
            guard_q <= latch_pulse & mask_nz;
        end
    end
`else
    assign guard_q = 1'b0;
`endif

    assign output_enable         = (counter != '0) && !guard_q;
    assign exceeded_overlap_time = exceeded;

endmodule

// File: tb/tb_brightness_timeout.sv
// Randomized scoreboard bench for brightness_timeout; expectations come from a
// window model (latch edge + weight) evaluated per clock edge.

module tb_brightness_timeout;

    localparam int BASE_TICKS = 4;
    localparam int W = 8;

    typedef struct packed {
        logic oe;
        logic exc;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         row_latch = 1'b0;
    logic [W-1:0] mask = '0;
    logic         oe;
    logic         exc;

    brightness_timeout #(
        ._UNUSED   (0),
        .BASE_TICKS(BASE_TICKS)
    ) dut (
        .clk_in                (clk_in),
        .reset                 (reset),
        .row_latch             (row_latch),
        .brightness_mask_active(mask),
        .output_enable         (oe),
        .exceeded_overlap_time (exc)
    );

    always #5 clk_in = ~clk_in;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    // model state: last accepted latch edge and its window length
    int   edge_k = 0;
    bit   have_latch = 1'b0;
    int   lat_n = 0;
    int   lat_t = 0;
    bit   prev_rl = 1'b0;

    function automatic int weight(logic [W-1:0] m);
        int v;
        v = int'(m);
        if (v == 0) return 0;
        return BASE_TICKS * (2 ** ($clog2(v + 1) - 1));
    endfunction

    function automatic exp_t expect_at(int k);
        exp_t e;
        int d;
        e = '0;
        if (!have_latch) return e;
        if (lat_t == 0) begin
            e.exc = 1'b1;
            return e;
        end
        d = k - lat_n;
`ifdef BRIGHTNESS_TIMEOUT_BLANK_GUARD_EN
        e.oe  = (d >= 1) && (d <= lat_t);
        e.exc = (d > lat_t);
`else
        e.oe  = (d < lat_t);
        e.exc = (d >= lat_t);
`endif
        return e;
    endfunction

    task automatic check(input string name, input int k, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s at step %0d: got oe,exc=%b required %b", name, k, act, req);
    endtask

    // one clock of stimulus; the expected response after the coming edge is queued
    task automatic step(input bit rst, input bit rl, input logic [W-1:0] m);
        @(negedge clk_in);
        if (rst && !reset) begin
            reset = 1'b1;
            #1;
            check("async_rst", edge_k, {oe, exc}, 2'b00);
        end
        reset     = rst;
        row_latch = rl;
        mask      = m;
        if (rst) begin
            have_latch = 1'b0;
            prev_rl    = 1'b0;
            sb_q.push_back('0);
        end else begin
            if (rl && !prev_rl) begin
                have_latch = 1'b1;
                lat_n      = edge_k;
                lat_t      = weight(m);
            end
            prev_rl = rl;
            sb_q.push_back(expect_at(edge_k));
        end
        edge_k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, W'($urandom));
    endtask

    int mon_k = 0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cycle", mon_k, {oe, exc}, {e.oe, e.exc});
                mon_k++;
            end
        end
    end

    initial begin : stimulus
        bit rl;
        logic [W-1:0] m;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h80 >> i);
        idle(4);

        step(1'b0, 1'b1, 8'h02);
        idle(8 + 8 * W);

        step(1'b0, 1'b1, 8'h80);
        idle(BASE_TICKS * 128 + 6);

        step(1'b0, 1'b1, 8'h00);
        idle(5);

        step(1'b0, 1'b1, 8'h04);
        idle(4);
        step(1'b0, 1'b1, 8'h01);
        idle(10);

        step(1'b0, 1'b1, 8'h01);
        idle(BASE_TICKS - 1);
        step(1'b0, 1'b1, 8'h01);
        idle(10);

        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h01);
        idle(10);
        step(1'b1, 1'b0, 8'h10);
        step(1'b1, 1'b0, 8'h10);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            rl = row_latch ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 9))
                0: m = '0;
                1: m = W'($urandom);
                default: m = W'(1) << $urandom_range(0, 5);
            endcase
            step($urandom_range(0, 199) == 0, rl, m);
        end

        repeat (3) @(negedge clk_in);
        check("drain", edge_k, {1'b0, sb_q.size() != 0}, 2'b00);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
